// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and helpers for the M-extension multiply/divide unit.
//   - func3 op codes (MUL..REMU) and the required func7 value
//   - FSM state encoding
//   - operand signedness decode helpers
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // rs1 is treated as signed by MULH, MULHSU, DIV and REM
   function automatic logic a_is_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   // rs2 is treated as signed by MULH, DIV and REM
   function automatic logic b_is_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_restoring_step.sv
// muldiv_restoring_step: one combinational iteration of a restoring divider.
//   rem          - partial remainder entering this step (always < divisor)
//   dividend_bit - next dividend bit shifted into the remainder
//   divisor      - divisor magnitude
//   rem_next     - partial remainder after the trial subtract
//   q_bit        - quotient bit produced by this step (1 when no borrow)
module muldiv_restoring_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rem,
   input  logic            dividend_bit,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic            q_bit
);

   logic [XLEN:0]   shifted;
   logic [XLEN+1:0] diff;

   // The shifted remainder is below 2*divisor, so a successful subtract fits XLEN bits.
   always_comb begin
      shifted  = {rem, dividend_bit};
      diff     = {1'b0, shifted} - {2'b00, divisor};
      q_bit    = ~diff[XLEN+1];
      rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M multiply/divide execution unit.
// Iterative shift-add multiplier and restoring divider behind a start/busy/done
// handshake. Optional build macro FAST_MUL_EN replaces the iterative multiply
// with a single-cycle combinational product; divide is unchanged.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   start, flush    - launch an op (IDLE only) / cancel the in-flight op
//   func7, func3    - M-extension R-type decode fields
//   op_a, op_b      - rs1 / rs2 values
//   busy            - op in flight (CALC/FIX)
//   done, illegal   - one-cycle completion pulse, bad func7 flag valid with done
//   result          - result, held until the next completion
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [6:0]      func7,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic            illegal,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0] SIGN_MIN = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

   state_t              state;
   logic [CNT_W-1:0]    count;
   logic [2:0]          op_f3;
   logic                neg_a;
   logic                neg_b;
   logic [XLEN-1:0]     mcand;
   logic [2*XLEN-1:0]   acc;

   // Launch-time decode of the live inputs
   logic                a_neg;
   logic                b_neg;
   logic [XLEN-1:0]     abs_a;
   logic [XLEN-1:0]     abs_b;
   logic                bad_func7;
   logic                div_zero;
   logic                div_ovf;
   logic                short_cut;
   logic [XLEN-1:0]     short_result;

   always_comb begin
      a_neg        = a_is_signed(func3) & op_a[XLEN-1];
      b_neg        = b_is_signed(func3) & op_b[XLEN-1];
      abs_a        = a_neg ? -op_a : op_a;
      abs_b        = b_neg ? -op_b : op_b;
      bad_func7    = (func7 != FUNC7_MULDIV);
      div_zero     = func3[2] && (op_b == '0);
      div_ovf      = ((func3 == F3_DIV) || (func3 == F3_REM)) &&
                     (op_a == SIGN_MIN) && (op_b == ALL_ONES);
      short_cut    = bad_func7 | div_zero | div_ovf;
      short_result = '0;
      // func3[1] separates REM/REMU from DIV/DIVU
      if (bad_func7) begin
         short_result = '0;
      end else if (div_zero) begin
         short_result = func3[1] ? op_a : ALL_ONES;
      end else if (div_ovf) begin
         short_result = func3[1] ? '0 : op_a;
      end
   end

`ifdef FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   logic [XLEN-1:0]   fast_result;

   // Sign/zero-extend to 2*XLEN so one unsigned multiply covers every multiply form
   always_comb begin
      fast_prod   = {{XLEN{a_neg}}, op_a} * {{XLEN{b_neg}}, op_b};
      fast_result = (func3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
   end
`endif

   // One multiply iteration: conditionally add multiplicand to upper half, shift right
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;

   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
      mul_next = {mul_sum, acc[XLEN-1:1]};
   end

   // Divide iteration: upper half is the remainder, lower half shifts dividend out / quotient in
   logic [XLEN-1:0]   rem_next;
   logic              q_bit;
   logic [2*XLEN-1:0] div_next;

   muldiv_restoring_step #(
      .XLEN (XLEN)
   ) u_step (
      .rem          (acc[2*XLEN-1:XLEN]),
      .dividend_bit (acc[XLEN-1]),
      .divisor      (mcand),
      .rem_next     (rem_next),
      .q_bit        (q_bit)
   );

   always_comb begin
      div_next = {rem_next, acc[XLEN-2:0], q_bit};
   end

   // Sign correction and result selection for the FIX state
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;
   logic [XLEN-1:0]   fix_result;

   always_comb begin
      prod_fix = (neg_a ^ neg_b) ? -acc : acc;
      quo_fix  = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_fix  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      if (op_f3[2]) begin
         fix_result = op_f3[1] ? rem_fix : quo_fix;
      end else if (op_f3 == F3_MUL) begin
         fix_result = prod_fix[XLEN-1:0];
      end else begin
         fix_result = prod_fix[2*XLEN-1:XLEN];
      end
   end

   // Control FSM with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         op_f3   <= '0;
         neg_a   <= 1'b0;
         neg_b   <= 1'b0;
         mcand   <= '0;
         acc     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         illegal <= 1'b0;
         result  <= '0;
      end else if (flush) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               illegal <= 1'b0;
               if (start) begin
                  op_f3 <= func3;
                  neg_a <= a_neg;
                  neg_b <= b_neg;
                  count <= CNT_W'(XLEN);
                  if (short_cut) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     illegal <= bad_func7;
                     result  <= short_result;
                  end
`ifdef FAST_MUL_EN
                  else if (!func3[2]) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     result <= fast_result;
                  end
`endif
                  else begin
                     state <= CALC;
                     busy  <= 1'b1;
                     if (func3[2]) begin
                        acc   <= {{XLEN{1'b0}}, abs_a};
                        mcand <= abs_b;
                     end else begin
                        acc   <= {{XLEN{1'b0}}, abs_b};
                        mcand <= abs_a;
                     end
                  end
               end
            end
            CALC: begin
               acc   <= op_f3[2] ? div_next : mul_next;
               count <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               result <= fix_result;
               busy   <= 1'b0;
               done   <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               done    <= 1'b0;
               illegal <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (XLEN=32).
// Directed vector table, handshake corner sequences (start while busy, flush,
// reset mid-op) and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int unsigned XLEN = 32;

   logic            clk;
   logic            reset;
   logic            start;
   logic            flush;
   logic [6:0]      func7;
   logic [2:0]      func3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            busy;
   logic            done;
   logic            illegal;
   logic [XLEN-1:0] result;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .flush   (flush),
      .func7   (func7),
      .func3   (func3),
      .op_a    (op_a),
      .op_b    (op_b),
      .busy    (busy),
      .done    (done),
      .illegal (illegal),
      .result  (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      logic        exp_ill;
   } vec_t;

   function automatic vec_t mk(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] r, input logic ill);
      vec_t v;
      v.f7 = f7; v.f3 = f3; v.a = a; v.b = b; v.exp_res = r; v.exp_ill = ill;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: {illegal, result} from plain 64-bit arithmetic and the RISC-V M rules
   function automatic logic [32:0] ref_model(input logic [6:0] f7, input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] b);
      int          ia;
      int          ib;
      longint      sa;
      longint      sb;
      longint      ub;
      logic [63:0] p;
      logic [31:0] r;
      logic        ovf;
      ia  = a;
      ib  = b;
      sa  = ia;
      sb  = ib;
      ub  = {32'h0, b};
      r   = '0;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (f7 != 7'b0000001) return {1'b1, 32'h0};
      case (f3)
         F3_MUL:    begin p = sa * sb; r = p[31:0]; end
         F3_MULH:   begin p = sa * sb; r = p[63:32]; end
         F3_MULHSU: begin p = sa * ub; r = p[63:32]; end
         F3_MULHU:  begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
         F3_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
         F3_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         F3_REM:    r = (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
         default:   r = (b == 0) ? a : a % b;
      endcase
      return {1'b0, r};
   endfunction

   // Expected start-to-done latency in cycles (start edge counts as 1)
   function automatic int exp_lat(input logic [6:0] f7, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b);
      if (f7 != 7'b0000001) return 1;
      if (f3[2] && (b == 0)) return 1;
      if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef FAST_MUL_EN
      if (!f3[2]) return 1;
`endif
      return XLEN + 2;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'h0;
         1:       v = 32'h1;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'h8000_0000;
         4:       v = 32'h7FFF_FFFF;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Launch one op and watch it; kick_kind 1/2/3 raises start/flush/reset at cycle kick_at.
   task automatic do_op(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int kick_at, input int kick_kind,
                        output logic [31:0] res, output logic ill, output int lat,
                        output logic got, output logic done_next, output logic [31:0] res_next,
                        output logic busy_k, output logic [31:0] res_k);
      res = '0; ill = 1'b0; got = 1'b0; done_next = 1'b0; res_next = '0;
      busy_k = 1'b1; res_k = '0; lat = 1;
      @(negedge clk);
      func7 = f7; func3 = f3; op_a = a; op_b = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op_a  = $urandom;
      op_b  = $urandom;
      func3 = 3'($urandom);
      while (lat <= 60) begin
         if (kick_kind != 0 && lat == kick_at + 1) begin
            busy_k = busy;
            res_k  = result;
         end
         if (done) begin
            got = 1'b1;
            res = result;
            ill = illegal;
            break;
         end
         if (lat == kick_at) begin
            case (kick_kind)
               1: begin start = 1'b1; op_a = 32'd1000; op_b = 32'd3; end
               2: flush = 1'b1;
               3: reset = 1'b1;
               default: ;
            endcase
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         flush = 1'b0;
         reset = 1'b0;
         lat++;
      end
      if (got) begin
         @(posedge clk);
         #1;
         done_next = done;
         res_next  = result;
      end
   endtask

   initial begin
      vec_t        vecs[$];
      logic [31:0] res;
      logic [31:0] rn;
      logic [31:0] rk;
      logic        ill;
      logic        got;
      logic        dn;
      logic        bk;
      int          lat;
      logic [32:0] m;
      logic [6:0]  rf7;
      logic [2:0]  rf3;
      logic [31:0] ra;
      logic [31:0] rb;

      vecs.push_back(mk(7'h01, F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0));
      vecs.push_back(mk(7'h01, F3_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0));
      vecs.push_back(mk(7'h01, F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0));
      vecs.push_back(mk(7'h01, F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0));
      vecs.push_back(mk(7'h01, F3_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 1'b0));
      vecs.push_back(mk(7'h01, F3_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 1'b0));
      vecs.push_back(mk(7'h01, F3_DIVU,   32'd20,         32'd3,         32'd6,         1'b0));
      vecs.push_back(mk(7'h01, F3_REMU,   32'd20,         32'd3,         32'd2,         1'b0));
      vecs.push_back(mk(7'h01, F3_DIV,    32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0));
      vecs.push_back(mk(7'h01, F3_REM,    32'd20,         32'hFFFF_FFFD, 32'd2,         1'b0));
      vecs.push_back(mk(7'h01, F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0));
      vecs.push_back(mk(7'h01, F3_REM,    32'd5,          32'd0,         32'd5,         1'b0));
      vecs.push_back(mk(7'h01, F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0));
      vecs.push_back(mk(7'h01, F3_REMU,   32'd5,          32'd0,         32'd5,         1'b0));
      vecs.push_back(mk(7'h01, F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0));
      vecs.push_back(mk(7'h01, F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1'b0));
      vecs.push_back(mk(7'h01, F3_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1'b0));
      vecs.push_back(mk(7'h20, F3_MUL,    32'd6,          32'd7,         32'h0,         1'b1));
      vecs.push_back(mk(7'h01, F3_MUL,    32'd6,          32'd7,         32'd42,        1'b0));

      reset = 1'b1; start = 1'b0; flush = 1'b0;
      func7 = '0; func3 = '0; op_a = '0; op_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'h0);
      check("reset_done", 64'(done), 64'h0);
      check("reset_illegal", 64'(illegal), 64'h0);
      check("reset_result", 64'(result), 64'h0);
      @(negedge clk);
      reset = 1'b0;

      // Directed vector table
      for (int i = 0; i < vecs.size(); i++) begin
         do_op(vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b, 0, 0,
               res, ill, lat, got, dn, rn, bk, rk);
         check($sformatf("vec%0d_done_seen", i), 64'(got), 64'h1);
         check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp_res));
         check($sformatf("vec%0d_illegal", i), 64'(ill), 64'(vecs[i].exp_ill));
         check($sformatf("vec%0d_latency", i), 64'(lat),
               64'(exp_lat(vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b)));
         check($sformatf("vec%0d_done_pulse", i), 64'(dn), 64'h0);
         check($sformatf("vec%0d_result_hold", i), 64'(rn), 64'(vecs[i].exp_res));
      end

      // start while busy is ignored: 100/7 still completes normally
      do_op(7'h01, F3_DIVU, 32'd100, 32'd7, 10, 1, res, ill, lat, got, dn, rn, bk, rk);
      check("busy_start_still_busy", 64'(bk), 64'h1);
      check("busy_start_done_seen", 64'(got), 64'h1);
      check("busy_start_result", 64'(res), 64'd14);
      check("busy_start_latency", 64'(lat), 64'(XLEN + 2));

      // flush at cycle 10: busy drops, no done, result keeps 14
      do_op(7'h01, F3_DIVU, 32'd1000, 32'd3, 10, 2, res, ill, lat, got, dn, rn, bk, rk);
      check("flush_busy", 64'(bk), 64'h0);
      check("flush_result_kept", 64'(rk), 64'd14);
      check("flush_no_done", 64'(got), 64'h0);

      // reset at cycle 15 of a long op clears everything
`ifdef FAST_MUL_EN
      do_op(7'h01, F3_DIVU, 32'd123, 32'd4, 15, 3, res, ill, lat, got, dn, rn, bk, rk);
`else
      do_op(7'h01, F3_MUL, 32'd123, 32'd456, 15, 3, res, ill, lat, got, dn, rn, bk, rk);
`endif
      check("reset_mid_busy", 64'(bk), 64'h0);
      check("reset_mid_result", 64'(rk), 64'h0);
      check("reset_mid_no_done", 64'(got), 64'h0);
      do_op(7'h01, F3_MUL, 32'd6, 32'd7, 0, 0, res, ill, lat, got, dn, rn, bk, rk);
      check("after_reset_mul_result", 64'(res), 64'd42);
      check("after_reset_mul_latency", 64'(lat), 64'(exp_lat(7'h01, F3_MUL, 32'd6, 32'd7)));

      // Randomized ops against the reference model
      for (int n = 0; n < 250; n++) begin
         rf7 = ($urandom_range(0, 15) == 0) ? 7'($urandom) : 7'b0000001;
         rf3 = 3'($urandom);
         ra  = pick();
         rb  = pick();
         m   = ref_model(rf7, rf3, ra, rb);
         do_op(rf7, rf3, ra, rb, 0, 0, res, ill, lat, got, dn, rn, bk, rk);
         check($sformatf("rand%0d_f3=%0d_a=%h_b=%h_result", n, rf3, ra, rb), 64'(res), 64'(m[31:0]));
         check($sformatf("rand%0d_illegal", n), 64'(ill), 64'(m[32]));
         check($sformatf("rand%0d_latency", n), 64'(lat), 64'(exp_lat(rf7, rf3, ra, rb)));
         check($sformatf("rand%0d_done_seen", n), 64'(got), 64'h1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RV32M/RV64M execution unit; successor to the combinational ALU control decode.
- Decodes func7/func3 of M-extension R-type ops and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Uses an iterative shift-add multiplier and a restoring divider behind a start/busy/done handshake.
- Sits beside the main ALU in EX; the core stalls while busy is high.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not to be overridden).

Ports:
- clk input 1 — rising-edge clock.
- reset input 1 — synchronous, active-high reset.
- start input 1 — launch operation; sampled only in IDLE.
- flush input 1 — synchronous cancel of the in-flight op; no done is produced.
- func7 input 7 — instruction func7; 7'b0000001 required.
- func3 input 3 — op select.
- op_a input XLEN — rs1 value.
- op_b input XLEN — rs2 value.
- busy output 1 — high from the cycle after an accepted start until done.
- done output 1 — one-cycle pulse; result valid in the same cycle.
- illegal output 1 — valid with done; func7 was not 0000001.
- result output XLEN — held stable from done until the next accepted start.

Behaviour:
- Reset (reset=1 at a clock edge): state=IDLE; busy=0, done=0, illegal=0, result=0; counter and internal registers cleared. Applies mid-operation; no done is emitted.
- func3 decode: 000 MUL (low XLEN bits); 001 MULH (s×s, high); 010 MULHSU (s×u, high); 011 MULHU (u×u, high); 100 DIV; 101 DIVU; 110 REM; 111 REMU.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1:
  - Latch operands, func3 and signedness; take absolute values for signed operands; record result sign.
  - Next state CALC, counter=XLEN, busy=1.
  - Short-circuits go directly to DONE: illegal func7, divide-by-zero, signed overflow.
- CALC: one iteration per cycle; counter decrements; at counter==1 go to FIX.
  - Multiply: 2·XLEN-bit accumulator, shift-add, LSB first.
  - Divide: restoring; shift remainder left, trial subtract, quotient bit = ~borrow.
- FIX:
  - Apply two's-complement negation when the recorded sign is negative.
  - Multiply sign = sa^sb for the signed/signed-unsigned forms.
  - Quotient sign = sa^sb; remainder takes the dividend's sign.
  - Select the high or low half / quotient or remainder; register result. Go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; return to IDLE. start is not accepted in DONE.
- Latency from accepted start to done:
  - Normal ops: XLEN+2 cycles (34 for XLEN=32).
  - Short-circuits: 1 cycle.
- Divide-by-zero (op_b=0):
  - DIV/DIVU: result all ones.
  - REM/REMU: result = op_a.
- Signed overflow (DIV/REM, op_a = 1<<(XLEN-1), op_b = all ones): DIV result = op_a; REM result = 0.
- Illegal func7: done after 1 cycle, illegal=1, result=0.
- start while busy: ignored, with no effect on the in-flight op.
- flush: any state goes to IDLE next cycle with busy=0 and done=0; result keeps its previous value. flush overrides a simultaneous start. reset overrides flush.
- Operands may change after the start cycle; the unit uses only latched copies.

Optional Feature:
- FAST_MUL_EN defined:
  - All multiply ops use a single combinational 2·XLEN product registered in IDLE→DONE.
  - Multiply latency is 1 cycle. Divide behaviour is unchanged.
- FAST_MUL_EN undefined: multiplies use the iterative CALC path with XLEN+2 latency.
- Port list is identical in both builds.

Decomposition:
- Shared package muldiv_pkg:
  - func3 localparams (MUL..REMU).
  - FUNC7_MULDIV = 7'b0000001.
  - State encoding (IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3).
- Sub-module muldiv_restoring_step: combinational single iteration for the divider.
  - Inputs: remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once inside muldiv_unit.

Test Plan:
- MUL, op_a=7, op_b=-3 (0xFFFFFFFD) → done at cycle 34, result=0xFFFFFFEB; MULH same operands → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV -20/3 → 0xFFFFFFFA (-6); REM -20/3 → 0xFFFFFFFE (-2); DIVU 20/3 → 6; REMU 20/3 → 2.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0; each done 1 cycle after start.
- func7=0100000 with start → done next cycle, illegal=1, result=0.
- start DIVU, then at cycle 10 raise start with new operands → ignored, original result delivered; separate run: flush at cycle 10 → busy=0 next cycle, no done pulse, result unchanged.
- reset asserted at cycle 15 of a MUL → busy=0, done=0, result=0 next cycle; a fresh MUL 6×7 then returns 42. With FAST_MUL_EN, MUL 6×7 gives done 1 cycle after start, result=42.
